// File: rtl/cache_mem_arbiter_pkg.sv
// Shared constants for the I/D-cache to main-memory arbiter.
// State, owner and line geometry definitions used across the slice.
package cache_mem_arbiter_pkg;

    localparam int WORD_SIZE   = 32;
    localparam int BLOCK_SIZE  = 4;
    localparam int CNT_BITS    = $clog2(BLOCK_SIZE);
    localparam int LINE_BITS   = WORD_SIZE * BLOCK_SIZE;
    localparam int OFFSET_BITS = 2 + CNT_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache-side and memory-side handshake bundle of the arbiter.
// master = arbiter, slave = caches plus memory model.
interface cache_mem_arbiter_if #(
    parameter int Word_Size  = 32,
    parameter int Block_Size = 4
);
    localparam int LW = Word_Size * Block_Size;

    logic                 ic_req;
    logic [Word_Size-1:0] ic_addr;
    logic [LW-1:0]        ic_rdata;
    logic                 ic_done;

    logic                 dc_req;
    logic                 dc_we;
    logic [Word_Size-1:0] dc_addr;
    logic [LW-1:0]        dc_wdata;
    logic [LW-1:0]        dc_rdata;
    logic                 dc_done;

    logic                 mem_ready;
    logic [Word_Size-1:0] mem_rdata;
    logic [Word_Size-1:0] mem_addr;
    logic [Word_Size-1:0] mem_wdata;
    logic                 mem_read;
    logic                 mem_write;

    modport master (
        input  ic_req, ic_addr,
        input  dc_req, dc_we, dc_addr, dc_wdata,
        input  mem_ready, mem_rdata,
        output ic_rdata, ic_done,
        output dc_rdata, dc_done,
        output mem_addr, mem_wdata,
        output mem_read, mem_write
    );

    modport slave (
        output ic_req, ic_addr,
        output dc_req, dc_we, dc_addr, dc_wdata,
        output mem_ready, mem_rdata,
        input  ic_rdata, ic_done,
        input  dc_rdata, dc_done,
        input  mem_addr, mem_wdata,
        input  mem_read, mem_write
    );

endinterface

// File: rtl/cache_mem_arbiter_arb_pick.sv
// Grant selection between I-cache and D-cache requests.
// ARB_RR_EN: round-robin on ties via last_grant, else fixed D priority.
module cache_mem_arbiter_arb_pick (
    input  logic clk,
    input  logic reset_pin,
    input  logic ic_req_i,
    input  logic dc_req_i,
    input  logic grant_en_i,
    output logic sel_d_o
);

`ifdef ARB_RR_EN
    logic last_q, last_d;
    logic tie;

    assign tie = ic_req_i & dc_req_i;

    always_comb begin
        sel_d_o = 1'b0;
        unique case (1'b1)
            tie:      sel_d_o = ~last_q;
            dc_req_i: sel_d_o = 1'b1;
            default:  sel_d_o = 1'b0;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (grant_en_i & (ic_req_i | dc_req_i)) begin
            last_d = sel_d_o;
        end
    end

    // last_q = 1 means the D-cache holds the most recent grant
    always_ff @(posedge clk) begin
        if (reset_pin) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`else
    logic unused_ok;

    assign unused_ok = &{1'b0, clk, reset_pin,
                         ic_req_i, grant_en_i};
    assign sel_d_o   = dc_req_i;
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// Serialises I-fill, D-fill and D-writeback lines into word bursts.
// Optional ARB_RR_EN switches tie-breaking to round-robin.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int Word_Size  = WORD_SIZE,
    parameter int Block_Size = BLOCK_SIZE
) (
    input  logic                clk,
    input  logic                reset_pin,
    cache_mem_arbiter_if.master bus
);

    localparam int CB = $clog2(Block_Size);
    localparam int LB = Word_Size * Block_Size;
    localparam int OB = 2 + CB;
    localparam int TB = Word_Size - OB;
    localparam logic [CB-1:0] LAST = CB'(Block_Size - 1);

    state_e          state_q, state_d;
    owner_e          owner_q, owner_d;
    logic            we_q, we_d;
    logic [TB-1:0]   tag_q, tag_d;
    logic [LB-1:0]   wdata_q, wdata_d;
    logic [LB-1:0]   line_q, line_d;
    logic [CB-1:0]   cnt_q, cnt_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic            ic_done_q, ic_done_d;
    logic            dc_done_q, dc_done_d;
    logic [LB-1:0]   ic_line_q, ic_line_d;
    logic [LB-1:0]   dc_line_q, dc_line_d;

    logic            grant_en;
    logic            grant;
    logic            sel_d;
    logic            beat;
    logic            last_beat;
    logic [LB-1:0]   line_nx;
    logic            unused_ok;

    assign grant_en  = (state_q == IDLE);
    assign grant     = grant_en & (bus.ic_req | bus.dc_req);
    assign beat      = (state_q == BURST) & bus.mem_ready;
    assign last_beat = beat & (cnt_q == LAST);
    assign unused_ok = &{1'b0, bus.ic_addr[OB-1:0],
                         bus.dc_addr[OB-1:0]};

    cache_mem_arbiter_arb_pick u_arb_pick (
        .clk        (clk),
        .reset_pin  (reset_pin),
        .ic_req_i   (bus.ic_req),
        .dc_req_i   (bus.dc_req),
        .grant_en_i (grant_en),
        .sel_d_o    (sel_d)
    );

    // Line buffer with the current read beat merged in
    always_comb begin
        line_nx = line_q;
        if (!we_q) begin
            line_nx[cnt_q*Word_Size +: Word_Size] = bus.mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_pin) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant) state_d = BURST;
            BURST:   if (last_beat) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d   = owner_q;
        we_d      = we_q;
        tag_d     = tag_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        line_d    = line_q;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        ic_done_d = 1'b0;
        dc_done_d = 1'b0;
        ic_line_d = ic_line_q;
        dc_line_d = dc_line_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    owner_d = sel_d ? OWN_D : OWN_I;
                    we_d    = sel_d & bus.dc_we;
                    tag_d   = sel_d ? bus.dc_addr[Word_Size-1:OB]
                                    : bus.ic_addr[Word_Size-1:OB];
                    wdata_d = sel_d ? bus.dc_wdata : '0;
                    cnt_d   = '0;
                    rd_d    = ~we_d;
                    wr_d    = we_d;
                end
            end
            BURST: begin
                rd_d = rd_q;
                wr_d = wr_q;
                if (beat) begin
                    line_d = line_nx;
                    cnt_d  = cnt_q + 1'b1;
                end
                if (last_beat) begin
                    rd_d      = 1'b0;
                    wr_d      = 1'b0;
                    ic_done_d = (owner_q == OWN_I);
                    dc_done_d = (owner_q == OWN_D);
                    if (owner_q == OWN_I) begin
                        ic_line_d = line_nx;
                    end else if (!we_q) begin
                        dc_line_d = line_nx;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_pin) begin
            owner_q   <= OWN_I;
            we_q      <= 1'b0;
            tag_q     <= '0;
            wdata_q   <= '0;
            line_q    <= '0;
            cnt_q     <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            ic_done_q <= 1'b0;
            dc_done_q <= 1'b0;
            ic_line_q <= '0;
            dc_line_q <= '0;
        end else begin
            owner_q   <= owner_d;
            we_q      <= we_d;
            tag_q     <= tag_d;
            wdata_q   <= wdata_d;
            line_q    <= line_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            ic_done_q <= ic_done_d;
            dc_done_q <= dc_done_d;
            ic_line_q <= ic_line_d;
            dc_line_q <= dc_line_d;
        end
    end

    assign bus.mem_addr  = {tag_q, cnt_q, 2'b00};
    assign bus.mem_wdata = wdata_q[cnt_q*Word_Size +: Word_Size];
    assign bus.mem_read  = rd_q;
    assign bus.mem_write = wr_q;
    assign bus.ic_done   = ic_done_q;
    assign bus.dc_done   = dc_done_q;
    assign bus.ic_rdata  = ic_line_q;
    assign bus.dc_rdata  = dc_line_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with a wait-state memory model.
// Expectations for the tie cases follow ARB_RR_EN when it is defined.
module tb_cache_mem_arbiter;

    logic clk = 1'b0;
    logic reset_pin;

    always #5 clk = ~clk;

    cache_mem_arbiter_if bus ();

    cache_mem_arbiter dut (
        .clk       (clk),
        .reset_pin (reset_pin),
        .bus       (bus)
    );

`ifdef ARB_RR_EN
    localparam int TIE2_I_LAT = 5;
    localparam int TIE2_D_LAT = 11;
`else
    localparam int TIE2_I_LAT = 11;
    localparam int TIE2_D_LAT = 5;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int          waits   = 0;
    logic [31:0] rd_base = 32'h0;
    int          wcnt    = 0;
    int          glitch  = 0;
    int          rd_cyc  = 0;
    int          wr_cyc  = 0;
    logic        strobe;
    logic        p_str   = 1'b0;
    logic        p_rdy   = 1'b0;
    logic [31:0] p_addr  = 32'h0;
    logic [31:0] p_wd    = 32'h0;
    logic [31:0] log_a[$];
    logic [31:0] log_w[$];
    bit          log_we[$];

    int           t0, nlog, viol;
    int           i_cyc, d_cyc;
    logic [127:0] i_ln, d_ln;
    bit           p_idn, p_ddn;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: answers each beat after `waits` idle cycles
    always @(negedge clk) begin
        strobe = bus.mem_read | bus.mem_write;
        if (strobe && p_str && !p_rdy &&
            (bus.mem_addr !== p_addr ||
             bus.mem_wdata !== p_wd)) glitch++;
        if (bus.mem_read)  rd_cyc++;
        if (bus.mem_write) wr_cyc++;
        if (reset_pin || !strobe) begin
            bus.mem_ready = 1'b0;
            bus.mem_rdata = 32'h0;
            wcnt = 0;
        end else if (wcnt >= waits) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = rd_base + 32'(bus.mem_addr[3:2]);
            log_a.push_back(bus.mem_addr);
            log_w.push_back(bus.mem_wdata);
            log_we.push_back(bus.mem_write);
            wcnt = 0;
        end else begin
            bus.mem_ready = 1'b0;
            wcnt++;
        end
        p_str  = strobe;
        p_rdy  = bus.mem_ready;
        p_addr = bus.mem_addr;
        p_wd   = bus.mem_wdata;
    end

    task automatic chk(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pk_a(input int s);
        logic [127:0] r;
        for (int k = 0; k < 4; k++)
            r[32*k +: 32] = (s + k < log_a.size())
                          ? log_a[s+k] : 32'hDEADBEEF;
        return r;
    endfunction

    function automatic logic [127:0] pk_w(input int s);
        logic [127:0] r;
        for (int k = 0; k < 4; k++)
            r[32*k +: 32] = (s + k < log_w.size())
                          ? log_w[s+k] : 32'hDEADBEEF;
        return r;
    endfunction

    function automatic int n_we(input int s);
        int n = 0;
        for (int k = s; k < log_we.size(); k++)
            if (log_we[k]) n++;
        return n;
    endfunction

    function automatic logic [127:0] line4(input logic [31:0] b);
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    task automatic start(input bit ir, input logic [31:0] ia,
                         input bit dr, input bit dwe,
                         input logic [31:0] da,
                         input logic [127:0] dwd);
        @(posedge clk);
        #1;
        t0    = cyc;
        nlog  = log_a.size();
        p_idn = 1'b0;
        p_ddn = 1'b0;
        bus.ic_addr  = ia;
        bus.dc_we    = dwe;
        bus.dc_addr  = da;
        bus.dc_wdata = dwd;
        bus.ic_req   = ir;
        bus.dc_req   = dr;
    endtask

    task automatic run(input int ni, input int nd,
                       input bit drop, input int budget);
        int gi = 0;
        int gd = 0;
        for (int k = 0; k < budget && (gi < ni || gd < nd); k++) begin
            @(negedge clk);
            if ((p_idn && bus.ic_req) ||
                (p_ddn && bus.dc_req)) viol++;
            p_idn = bus.ic_done;
            p_ddn = bus.dc_done;
            if (bus.ic_done) begin
                gi++;
                i_cyc = cyc;
                i_ln  = bus.ic_rdata;
                if (drop) bus.ic_req = 1'b0;
            end
            if (bus.dc_done) begin
                gd++;
                d_cyc = cyc;
                d_ln  = bus.dc_rdata;
                if (drop) bus.dc_req = 1'b0;
            end
        end
        chk("done_count", {gi, gd}, {ni, nd});
    endtask

    initial begin
        int rd0, wr0, v0, extra;
        reset_pin    = 1'b1;
        bus.ic_req   = 1'b0;
        bus.ic_addr  = 32'h0;
        bus.dc_req   = 1'b0;
        bus.dc_we    = 1'b0;
        bus.dc_addr  = 32'h0;
        bus.dc_wdata = '0;
        viol         = 0;
        repeat (3) @(posedge clk);
        #1 reset_pin = 1'b0;
        @(negedge clk);
        chk("rst_strobes", {bus.mem_read, bus.mem_write,
                            bus.ic_done, bus.dc_done}, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_ic_rdata", bus.ic_rdata, 0);
        chk("rst_dc_rdata", bus.dc_rdata, 0);

        // I-fill, zero wait
        waits = 0; rd_base = 32'hA0;
        start(1, 32'h1234, 0, 0, 0, 0);
        run(1, 0, 1, 100);
        chk("t1_lat", i_cyc - t0, 5);
        chk("t1_line", i_ln, line4(32'hA0));
        chk("t1_addr", pk_a(nlog),
            {32'h123C, 32'h1238, 32'h1234, 32'h1230});
        chk("t1_nbeat", log_a.size() - nlog, 4);

        // D-writeback, 2 wait cycles per beat
        waits = 2;
        rd0 = rd_cyc; wr0 = wr_cyc;
        start(0, 0, 1, 1, 32'h2000,
              {32'h44, 32'h33, 32'h22, 32'h11});
        run(0, 1, 1, 100);
        chk("t2_lat", d_cyc - t0, 13);
        chk("t2_wr_cycles", wr_cyc - wr0, 12);
        chk("t2_rd_cycles", rd_cyc - rd0, 0);
        chk("t2_addr", pk_a(nlog),
            {32'h200C, 32'h2008, 32'h2004, 32'h2000});
        chk("t2_wdata", pk_w(nlog),
            {32'h44, 32'h33, 32'h22, 32'h11});
        chk("t2_nwe", n_we(nlog), 4);
        chk("t2_dc_rdata", d_ln, 0);

        // Ties from reset state
        @(negedge clk) reset_pin = 1'b1;
        @(negedge clk) reset_pin = 1'b0;
        waits = 0; rd_base = 32'hB0;
        start(1, 32'h100, 1, 0, 32'h200, 0);
        run(1, 1, 1, 100);
        chk("t3_d_lat", d_cyc - t0, 5);
        chk("t3_i_lat", i_cyc - t0, 11);
        chk("t3_first", log_a[nlog], 32'h200);
        chk("t3_second", log_a[nlog+4], 32'h100);
        chk("t3_d_line", d_ln, line4(32'hB0));
        chk("t3_i_line", i_ln, line4(32'hB0));
        start(0, 0, 1, 0, 32'h300, 0);
        run(0, 1, 1, 100);
        chk("t3_donly_lat", d_cyc - t0, 5);
        start(1, 32'h400, 1, 0, 32'h500, 0);
        run(1, 1, 1, 100);
        chk("t3_tie2_i", i_cyc - t0, TIE2_I_LAT);
        chk("t3_tie2_d", d_cyc - t0, TIE2_D_LAT);

        // D request raised during the 2nd beat of an I-fill
        rd_base = 32'hC0;
        start(1, 32'h1000, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        bus.dc_we   = 1'b0;
        bus.dc_addr = 32'h2040;
        bus.dc_req  = 1'b1;
        run(1, 1, 1, 100);
        chk("t4_i_lat", i_cyc - t0, 5);
        chk("t4_d_lat", d_cyc - t0, 11);
        chk("t4_d_addr", pk_a(nlog + 4),
            {32'h204C, 32'h2048, 32'h2044, 32'h2040});
        chk("t4_d_line", d_ln, line4(32'hC0));

        // Reset after two beats of a fill
        rd_base = 32'hD0;
        start(1, 32'h3000, 0, 0, 0, 0);
        repeat (4) @(negedge clk);
        reset_pin  = 1'b1;
        bus.ic_req = 1'b0;
        @(negedge clk);
        chk("t5_strobes", {bus.mem_read, bus.mem_write}, 0);
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.ic_done || bus.dc_done) extra++;
            @(negedge clk);
        end
        chk("t5_nodone", extra, 0);
        reset_pin = 1'b0;
        rd_base   = 32'hE0;
        start(1, 32'h3000, 0, 0, 0, 0);
        run(1, 0, 1, 100);
        chk("t5_lat", i_cyc - t0, 5);
        chk("t5_line", i_ln, line4(32'hE0));
        chk("t5_addr", pk_a(nlog),
            {32'h300C, 32'h3008, 32'h3004, 32'h3000});

        // Requester holding req across done is flagged
        rd_base = 32'hF0;
        v0 = viol;
        start(1, 32'h4000, 0, 0, 0, 0);
        run(1, 0, 0, 100);
        run(1, 0, 1, 100);
        chk("t6_viol", viol - v0, 1);
        chk("t6_regrant_lat", i_cyc - t0, 11);
        v0 = viol;
        start(1, 32'h5000, 0, 0, 0, 0);
        run(1, 0, 1, 100);
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.ic_done) extra++;
        end
        chk("t6_single_done", extra, 0);
        chk("t6_noviol", viol - v0, 0);
        chk("no_glitch", glitch, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
